mem_fill_arbiter: RTL
=====================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares the single-ported, multi-cycle main memory between three requesters:
//    - the I-cache miss handler
//    - the D-cache miss handler
//    - the MEM-stage write-through store path
//  Sequences BLOCK_WORDS-word block fills, steers returning words to the missing cache, and
//  raises busy so hazard logic can freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Sits between both caches and main memory, beside the MEM stage.
// PARAMETERS
//  ADDR_W       16  byte address width
//  DATA_W       16  word width (2-byte words; addr bit 0 always 0)
//  BLOCK_WORDS  8   words per cache block; power of 2, >=2
//  MEM_LATENCY  4   memory read latency in cycles; informational only, logic counts mem_rvalid
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       synchronous active-low reset
//  i_miss_req   in   1       I-cache miss; level, held until i_fill_done
//  i_miss_addr  in   ADDR_W  missing fetch address
//  d_miss_req   in   1       D-cache miss; level, held until d_fill_done
//  d_miss_addr  in   ADDR_W  missing data address
//  st_req       in   1       store write-through; level, dropped the cycle after st_ack
//  st_addr      in   ADDR_W  store address
//  st_data      in   DATA_W  store data
//  mem_en       out  1       memory access enable (registered)
//  mem_wr       out  1       1=write, 0=read (registered)
//  mem_addr     out  ADDR_W  memory address (registered)
//  mem_wdata    out  DATA_W  memory write data (registered)
//  mem_rdata    in   DATA_W  memory read data
//  mem_rvalid   in   1       mem_rdata valid this cycle
//  fill_data    out  DATA_W  = mem_rdata
//  fill_word    out  log2(BLOCK_WORDS)  word index within block being written
//  fill_we_i    out  1       write fill_data into I-cache line
//  fill_we_d    out  1       write fill_data into D-cache line
//  i_fill_done  out  1       one-cycle pulse: I fill complete
//  d_fill_done  out  1       one-cycle pulse: D fill complete
//  st_ack       out  1       one-cycle pulse: store issued to memory
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - state=IDLE; issue and receive counters = 0
//    - all outputs 0, including mem_addr and mem_wdata
//  - FSM states: IDLE, STORE, FILL, DRAIN, DONE.
//  - IDLE: sample requests. Fixed priority st_req > d_miss_req > i_miss_req.
//    - Latch the granted side (I/D), base = addr & ~(2*BLOCK_WORDS-1), and store addr/data.
//    - st_req -> STORE; miss -> FILL; no request -> stay IDLE.
//  - STORE (1 cycle):
//    - mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1.
//    - -> IDLE.
//  - FILL:
//    - Each cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt++.
//    - After issuing word BLOCK_WORDS-1 -> DRAIN; issue_cnt wraps to 0.
//  - FILL and DRAIN: each mem_rvalid cycle:
//    - fill_we_{granted side}=1, fill_word=recv_cnt, fill_data=mem_rdata
//      (combinational, same cycle as mem_rvalid); recv_cnt++.
//    - On receiving word BLOCK_WORDS-1 -> DONE; recv_cnt wraps to 0.
//    - The DONE transition may occur from FILL only if memory returns early; it is still
//      taken only after the last word is received.
//  - DONE (1 cycle): {i|d}_fill_done=1 for the granted side -> IDLE.
//    - The requester must drop its req this cycle; IDLE re-arbitrates next cycle.
//  - Latency, defaults, request first seen in IDLE at cycle N:
//    - mem_en cycles N+1..N+8
//    - rvalid cycles N+5..N+12
//    - fill_done at N+13
//    - busy high N+1..N+13
//    - Store: st_ack at N+1, busy N+1 only.
//  - mem_rvalid while IDLE or STORE is ignored: no fill_we, counters unchanged.
//    - This covers stale returns after a reset mid-fill.
//  - Request withdrawn mid-fill is not legal; the fill completes regardless.
//  - A new request during FILL/DRAIN/DONE waits until IDLE; no preemption.
//  - fill_we_i and fill_we_d are never both 1; mem_en=0 in IDLE, DRAIN and DONE.
// TESTING
//  - i_miss_req, addr 0x1236, rvalid 4 cycles after each read:
//    - reads 0x1230,0x1232..0x123E on consecutive cycles
//    - 8 fill_we_i pulses, fill_word 0..7
//    - i_fill_done at N+13; fill_we_d never set
//  - i_miss (0x0100) and d_miss (0x2008) raised same cycle:
//    - D fill of 0x2000..0x200E completes first with d_fill_done
//    - I fill of 0x0100 follows starting the cycle after IDLE
//  - st_req addr 0x0040, data 0xBEEF, with d_miss pending:
//    - mem_en=mem_wr=1, addr 0x0040, wdata 0xBEEF, st_ack on N+1
//    - D fill starts N+3
//  - rst_n=0 during FILL after 3 words received:
//    - next cycle all outputs 0, busy=0
//    - remaining rvalid pulses produce no fill_we
//    - a new i_miss then fills all 8 words from fill_word 0
//  - Memory with irregular rvalid gaps (stall 3 cycles mid-block):
//    - DRAIN holds until 8th rvalid, then single done pulse
//  - mem_rvalid pulsed while IDLE:
//    - no fill_we, no state change; following fill indexes from 0

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Shares one multi-cycle memory port between store write-through (highest), D-miss and I-miss fills.
// Fill: reads issued N+1..N+8, done pulse after the last returned word; busy freezes the pipeline meanwhile.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss_req,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss_req,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    input  logic                           st_req,
    input  logic [ADDR_W-1:0]              st_addr,
    input  logic [DATA_W-1:0]              st_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rvalid,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           fill_we_i,
    output logic                           fill_we_d,
    output logic                           i_fill_done,
    output logic                           d_fill_done,
    output logic                           st_ack,
    output logic                           busy
);

    localparam int                 IDX_W     = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0]  BASE_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    // Memory latency is not counted here; completion is tracked purely by mem_rvalid.
    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : g_param_check
        $error("mem_fill_arbiter: BLOCK_WORDS must be a power of 2 >= 2 and MEM_LATENCY >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   issue_cnt;
    logic [IDX_W-1:0]   issue_nxt;
    logic [IDX_W-1:0]   recv_cnt;
    logic [IDX_W-1:0]   recv_nxt;
    logic               side_d;
    logic               side_d_nxt;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  base_nxt;
    logic               en_nxt;
    logic               wr_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               rx;
    logic               rx_last;

    // Returns outside an active fill (idle, store, or stale after a reset) are dropped.
    assign rx      = mem_rvalid && (state == FILL || state == DRAIN);
    assign rx_last = rx && (recv_cnt == LAST_IDX);

    always_comb begin
        state_nxt  = state;
        issue_nxt  = issue_cnt;
        recv_nxt   = recv_cnt;
        side_d_nxt = side_d;
        base_nxt   = base;
        en_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;

        // Counter wraps to 0 on the last word because the block size is a power of 2.
        if (rx) begin
            recv_nxt = recv_cnt + IDX_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (st_req) begin
                    state_nxt = STORE;
                    en_nxt    = 1'b1;
                    wr_nxt    = 1'b1;
                    addr_nxt  = st_addr;
                    wdata_nxt = st_data;
                end else if (d_miss_req || i_miss_req) begin
                    side_d_nxt = d_miss_req;
                    base_nxt   = (d_miss_req ? d_miss_addr : i_miss_addr) & BASE_MASK;
                    issue_nxt  = '0;
                    state_nxt  = FILL;
                    en_nxt     = 1'b1;
                    addr_nxt   = base_nxt;
                end
            end
            STORE: begin
                state_nxt = IDLE;
            end
            FILL: begin
                if (rx_last) begin
                    state_nxt = DONE;
                    issue_nxt = '0;
                end else if (issue_cnt == LAST_IDX) begin
                    state_nxt = DRAIN;
                    issue_nxt = '0;
                end else begin
                    issue_nxt = issue_cnt + IDX_W'(1);
                    en_nxt    = 1'b1;
                    addr_nxt  = base + ADDR_W'({issue_nxt, 1'b0});
                end
            end
            DRAIN: begin
                if (rx_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            side_d    <= 1'b0;
            base      <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
            side_d    <= side_d_nxt;
            base      <= base_nxt;
            mem_en    <= en_nxt;
            mem_wr    <= wr_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    assign fill_data   = mem_rdata;
    assign fill_word   = recv_cnt;
    assign fill_we_i   = rx && !side_d;
    assign fill_we_d   = rx && side_d;
    assign i_fill_done = (state == DONE) && !side_d;
    assign d_fill_done = (state == DONE) && side_d;
    assign st_ack      = (state == STORE);
    assign busy        = (state != IDLE);

endmodule
